// File: rtl/ahb_lite_cordic_bridge_pkg.sv
// Shared constants for the AHB-Lite CORDIC bridge: register offsets, bit
// positions inside STATUS/CTRL/CLEAR, HRESP codes and FSM state encodings.
package cordic_bridge_pkg;

  // Register offsets as seen on HADDR[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  // STATUS bit positions
  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_IRQ_EN   = 2;

  // CLEAR bit positions
  localparam int CLR_FLUSH = 0;
  localparam int CLR_OVF   = 1;

  // Bus response codes and the only legal transfer size
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1    = 2'd2;
  localparam logic [1:0] ST_ERR2    = 2'd3;

  // Assemble the STATUS read word from its fields
  function automatic logic [31:0] make_status(input logic empty, input logic full,
                                              input logic ovf, input logic [7:0] cnt);
    logic [31:0] s;
    s = 32'd0;
    s[STAT_EMPTY] = empty;
    s[STAT_FULL]  = full;
    s[STAT_OVF]   = ovf;
    s[STAT_CNT_LSB +: 8] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/ahb_lite_cordic_bridge_if.sv
// AHB-Lite slave-side bus bundle for the CORDIC bridge.
interface ahb_lite_cordic_bridge_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_cordic_bridge_fifo.sv
// Result FIFO for the CORDIC bridge. Shift-register organisation so the head
// entry is always a flop (mem[0]); flush has priority over push and pop, and a
// pop together with a push while full is lossless.
module cordic_result_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic          do_pop;
  logic          do_push;
  logic [AW-1:0] wr_idx;

  assign empty   = (count == {CW{1'b0}});
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[0];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // After a shift the first free slot moves down by one
  assign wr_idx  = do_pop ? AW'(count - CW'(1)) : AW'(count);

  // Storage shift on pop, write at the tail on push, occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem[i] <= {W{1'b0}};
    end else if (flush) begin
      count <= {CW{1'b0}};
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (do_push) begin
        mem[wr_idx] <= push_data;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ahb_lite_cordic_bridge.sv
// AHB-Lite slave bridging the bus to a CORDIC core. DATA writes feed the core,
// DATA reads pop the result FIFO (stalling while it is empty), STATUS/CTRL/CLEAR
// give status and control. Optional macro CORDIC_BRIDGE_TIMEOUT_EN bounds the
// read stall to TIMEOUT_CYC cycles and then answers with ERROR.
module ahb_lite_cordic_bridge
  import cordic_bridge_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  ahb_lite_cordic_bridge_if.slave   bus,
  output logic [DATA_W-1:0]         cordic_in,
  output logic                      cordic_in_valid,
  output logic [1:0]                cordic_mode,
  input  logic [DATA_W-1:0]         cordic_out,
  input  logic                      cordic_out_valid,
  output logic                      irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        state, state_nxt;
  logic              hreadyout, hreadyout_nxt;
  logic [1:0]        hresp, hresp_nxt;
  logic [31:0]       hrdata, hrdata_nxt;

  logic              dp_valid;
  logic [1:0]        dp_addr;
  logic [1:0]        mode;
  logic              irq_en;
  logic              overflow;

  logic              accept, legal;
  logic [1:0]        addr;
  logic              wr_data, wr_ctrl, wr_clear;
  logic              flush_pend, ovf_clr;
  logic              eff_empty;
  logic [1:0]        mode_eff;
  logic              irq_en_eff;
  logic              pop, bypass, new_ovf;

  logic              fifo_push;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty, fifo_full;
  logic [CW-1:0]     fifo_count;

`ifdef CORDIC_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_clr, tmo_inc, tmo_hit;
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`endif

  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hreadyout;
  assign legal  = (bus.HSIZE == HSIZE_WORD);
  assign addr   = bus.HADDR[3:2];

  // Pending write data phase; its effect lands on the same edge as the next
  // address phase, so reads in that phase see the post-write values
  assign wr_data    = dp_valid & (dp_addr == REG_DATA);
  assign wr_ctrl    = dp_valid & (dp_addr == REG_CTRL);
  assign wr_clear   = dp_valid & (dp_addr == REG_CLEAR);
  assign flush_pend = wr_clear & bus.HWDATA[CLR_FLUSH];
  assign ovf_clr    = wr_clear & bus.HWDATA[CLR_OVF];
  assign eff_empty  = fifo_empty | flush_pend;
  assign mode_eff   = wr_ctrl ? bus.HWDATA[CTRL_MODE_LSB +: 2] : mode;
  assign irq_en_eff = wr_ctrl ? bus.HWDATA[CTRL_IRQ_EN] : irq_en;

  assign fifo_push = cordic_out_valid & ~bypass;
  assign new_ovf   = fifo_push & fifo_full & ~pop & ~flush_pend;

  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0], (TIMEOUT_CYC != 0)};

  cordic_result_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk       (HCLK),
    .rst       (HRESET),
    .push      (fifo_push),
    .push_data (cordic_out),
    .pop       (pop),
    .flush     (flush_pend),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Transfer FSM: decides response, read data and FIFO pop for the next cycle
  always_comb begin
    state_nxt     = state;
    hreadyout_nxt = hreadyout;
    hresp_nxt     = hresp;
    hrdata_nxt    = hrdata;
    pop           = 1'b0;
    bypass        = 1'b0;
`ifdef CORDIC_BRIDGE_TIMEOUT_EN
    tmo_clr       = 1'b0;
    tmo_inc       = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_ERR2: begin
        state_nxt     = ST_IDLE;
        hreadyout_nxt = 1'b1;
        hresp_nxt     = HRESP_OKAY;
        if (accept) begin
          if (!legal) begin
            state_nxt     = ST_ERR1;
            hreadyout_nxt = 1'b0;
            hresp_nxt     = HRESP_ERROR;
            hrdata_nxt    = 32'd0;
          end else if (bus.HWRITE) begin
            hrdata_nxt = hrdata;
          end else begin
            case (addr)
              REG_DATA: begin
                if (eff_empty) begin
                  state_nxt     = ST_RD_WAIT;
                  hreadyout_nxt = 1'b0;
`ifdef CORDIC_BRIDGE_TIMEOUT_EN
                  tmo_clr       = 1'b1;
`endif
                end else begin
                  hrdata_nxt = 32'(fifo_head);
                  pop        = 1'b1;
                end
              end
              REG_STATUS: hrdata_nxt = make_status(eff_empty, fifo_full & ~flush_pend,
                                                   overflow & ~ovf_clr,
                                                   flush_pend ? 8'd0 : 8'(fifo_count));
              REG_CTRL:   hrdata_nxt = 32'({irq_en_eff, mode_eff});
              REG_CLEAR:  hrdata_nxt = 32'd0;
              default:    hrdata_nxt = 32'd0;
            endcase
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (!fifo_empty) begin
          hrdata_nxt    = 32'(fifo_head);
          pop           = 1'b1;
          hreadyout_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end else if (cordic_out_valid) begin
          // Result goes straight to HRDATA instead of through the FIFO
          hrdata_nxt    = 32'(cordic_out);
          bypass        = 1'b1;
          hreadyout_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end else begin
`ifdef CORDIC_BRIDGE_TIMEOUT_EN
          if (tmo_hit) begin
            state_nxt     = ST_ERR1;
            hresp_nxt     = HRESP_ERROR;
            hrdata_nxt    = 32'd0;
          end else begin
            tmo_inc = 1'b1;
          end
`else
          state_nxt = ST_RD_WAIT;
`endif
        end
      end
      ST_ERR1: begin
        state_nxt     = ST_ERR2;
        hreadyout_nxt = 1'b1;
        hresp_nxt     = HRESP_ERROR;
      end
      default: begin
        state_nxt     = ST_IDLE;
        hreadyout_nxt = 1'b1;
        hresp_nxt     = HRESP_OKAY;
      end
    endcase
  end

  // FSM state and registered bus outputs
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      hrdata    <= 32'd0;
    end else begin
      state     <= state_nxt;
      hreadyout <= hreadyout_nxt;
      hresp     <= hresp_nxt;
      hrdata    <= hrdata_nxt;
    end
  end

  // Write data-phase tracking, register file, core strobe, overflow and irq
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid        <= 1'b0;
      dp_addr         <= 2'd0;
      cordic_in       <= {DATA_W{1'b0}};
      cordic_in_valid <= 1'b0;
      mode            <= 2'd0;
      irq_en          <= 1'b0;
      overflow        <= 1'b0;
      irq             <= 1'b0;
    end else begin
      dp_valid        <= accept & legal & bus.HWRITE;
      dp_addr         <= addr;
      cordic_in_valid <= wr_data;
      if (wr_data) cordic_in <= bus.HWDATA[DATA_W-1:0];
      mode            <= mode_eff;
      irq_en          <= irq_en_eff;
      overflow        <= (overflow & ~ovf_clr) | new_ovf;
      irq             <= irq_en & (~fifo_empty | overflow);
    end
  end

`ifdef CORDIC_BRIDGE_TIMEOUT_EN
  // Stall-cycle counter for the bounded read wait
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) tmo_cnt <= {TW{1'b0}};
    else if (tmo_clr) tmo_cnt <= {TW{1'b0}};
    else if (tmo_inc) tmo_cnt <= tmo_cnt + TW'(1);
    else tmo_cnt <= tmo_cnt;
  end
`endif

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata;
  assign cordic_mode   = mode;
endmodule

// File: tb/tb_ahb_lite_cordic_bridge.sv
// Directed bench for ahb_lite_cordic_bridge (single-slave bus: HREADY = HREADYOUT).
module tb_ahb_lite_cordic_bridge;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] cordic_in;
  logic        cordic_in_valid;
  logic [1:0]  cordic_mode;
  logic [31:0] cordic_out;
  logic        cordic_out_valid;
  logic        irq;

  int checks = 0;
  int failures = 0;

  ahb_lite_cordic_bridge_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_lite_cordic_bridge #(.DATA_W(32), .FIFO_DEPTH(8), .TIMEOUT_CYC(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus),
    .cordic_in(cordic_in), .cordic_in_valid(cordic_in_valid), .cordic_mode(cordic_mode),
    .cordic_out(cordic_out), .cordic_out_valid(cordic_out_valid), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One transfer; push_at = -1 pushes during the address phase, k >= 0 during
  // data-phase cycle k, anything else never pushes
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] size, input int push_at, input logic [31:0] push_val,
                      output logic [31:0] rdata, output logic [1:0] resp, output int waits);
    int k;
    bit done;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = wr; bus.HADDR = addr; bus.HSIZE = size;
    if (push_at == -1) begin cordic_out = push_val; cordic_out_valid = 1'b1; end
    tick();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = wdata;
    waits = 0; k = 0; done = 1'b0; rdata = 32'd0; resp = 2'b11;
    while (!done) begin
      if (k == push_at) begin cordic_out = push_val; cordic_out_valid = 1'b1; end
      else cordic_out_valid = 1'b0;
      if (bus.HREADYOUT) begin
        rdata = bus.HRDATA; resp = bus.HRESP; done = 1'b1;
      end else begin
        waits++;
        if (waits >= 200) begin
          checks++; failures++;
          $error("FAIL xfer_bound: got %0d wait states, expected completion", waits);
          done = 1'b1;
        end
      end
      tick();
      k++;
    end
    cordic_out_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] val);
    cordic_out = val; cordic_out_valid = 1'b1;
    tick();
    cordic_out_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    int          ws;
    HRESET = 1'b1; cordic_out = 32'd0; cordic_out_valid = 1'b0;
    bus.HSEL = 1'b0; bus.HADDR = 32'd0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b010; bus.HWDATA = 32'd0;
    tick(); tick();
    HRESET = 1'b0;
    tick();

    // Reset state
    check("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("rst_hresp", 32'(bus.HRESP), 32'd0);
    check("rst_hrdata", bus.HRDATA, 32'd0);
    check("rst_cordic_in", cordic_in, 32'd0);
    check("rst_in_valid", 32'(cordic_in_valid), 32'd0);
    check("rst_mode", 32'(cordic_mode), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    xfer(1'b0, 32'h4, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("rst_status", rd, 32'h0000_0001);

    // Operand write: strobe one cycle after the data phase, single cycle wide
    xfer(1'b1, 32'h0, 32'h0000_1234, 3'b010, -2, 32'd0, rd, rs, ws);
    check("wr_waits", 32'(ws), 32'd0);
    check("wr_cordic_in", cordic_in, 32'h0000_1234);
    check("wr_in_valid", 32'(cordic_in_valid), 32'd1);
    tick();
    check("wr_in_valid_drop", 32'(cordic_in_valid), 32'd0);

    // CTRL: mode=1, irq_en=1
    xfer(1'b1, 32'h8, 32'h0000_0005, 3'b010, -2, 32'd0, rd, rs, ws);
    check("ctrl_mode", 32'(cordic_mode), 32'd1);
    xfer(1'b0, 32'h8, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("ctrl_read", rd, 32'h0000_0005);

    // Stalled read: result arrives 5 cycles into the data phase -> 6 waits
    xfer(1'b0, 32'h0, 32'd0, 3'b010, 5, 32'h0000_ABCD, rd, rs, ws);
    check("stall_waits", 32'(ws), 32'd6);
    check("stall_data", rd, 32'h0000_ABCD);
    check("stall_resp", 32'(rs), 32'd0);
    xfer(1'b0, 32'h4, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("stall_status", rd, 32'h0000_0001);
    check("stall_irq", 32'(irq), 32'd0);

    // Non-empty reads are zero-wait and in order
    push(32'h11); push(32'h22);
    xfer(1'b0, 32'h0, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("pop1_data", rd, 32'h0000_0011);
    check("pop1_waits", 32'(ws), 32'd0);
    xfer(1'b0, 32'h4, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("pop1_status", rd, 32'h0000_0100);
    check("pop1_irq", 32'(irq), 32'd1);
    xfer(1'b0, 32'h0, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("pop2_data", rd, 32'h0000_0022);

    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) push(32'h100 + 32'(i));
    xfer(1'b0, 32'h4, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("ovf_status", rd, 32'h0000_0806);
    check("ovf_irq", 32'(irq), 32'd1);
    xfer(1'b0, 32'h0, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("ovf_head", rd, 32'h0000_0100);
    xfer(1'b1, 32'hC, 32'h0000_0002, 3'b010, -2, 32'd0, rd, rs, ws);
    check("ovf_clr_resp", 32'(rs), 32'd0);
    xfer(1'b0, 32'h4, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("ovf_clr_status", rd, 32'h0000_0700);

    // Full FIFO: pop and push on the same edge loses nothing
    push(32'h200);
    xfer(1'b0, 32'h4, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("full_status", rd, 32'h0000_0802);
    xfer(1'b0, 32'h0, 32'd0, 3'b010, -1, 32'h201, rd, rs, ws);
    check("full_pp_data", rd, 32'h0000_0101);
    xfer(1'b0, 32'h4, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("full_pp_status", rd, 32'h0000_0802);

    // Flush on the same edge as a push: FIFO ends empty
    xfer(1'b1, 32'hC, 32'h0000_0001, 3'b010, 0, 32'h300, rd, rs, ws);
    xfer(1'b0, 32'h4, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("flush_status", rd, 32'h0000_0001);

    // Byte write: two-cycle ERROR, CTRL untouched
    xfer(1'b1, 32'h8, 32'h0000_0000, 3'b000, -2, 32'd0, rd, rs, ws);
    check("err_resp", 32'(rs), 32'd1);
    check("err_waits", 32'(ws), 32'd1);
    xfer(1'b0, 32'h8, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("err_ctrl", rd, 32'h0000_0005);
    check("err_mode", 32'(cordic_mode), 32'd1);

    // STATUS write ignored with OKAY; CLEAR reads as zero
    xfer(1'b1, 32'h4, 32'hFFFF_FFFF, 3'b010, -2, 32'd0, rd, rs, ws);
    check("wst_resp", 32'(rs), 32'd0);
    xfer(1'b0, 32'h4, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("wst_status", rd, 32'h0000_0001);
    xfer(1'b0, 32'hC, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("clear_read", rd, 32'd0);

`ifdef CORDIC_BRIDGE_TIMEOUT_EN
    // Bounded stall: 16 RD_WAIT cycles + ERR1, then ERR2 completes
    xfer(1'b0, 32'h0, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("tmo_resp", 32'(rs), 32'd1);
    check("tmo_waits", 32'(ws), 32'd17);
    check("tmo_data", rd, 32'd0);
`endif

    // Stall on an empty read, then reset in the middle of it
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = 32'h0; bus.HSIZE = 3'b010;
    tick();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
`ifdef CORDIC_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < 8; i++) tick();
`else
    for (int i = 0; i < 100; i++) tick();
`endif
    check("stall_held", 32'(bus.HREADYOUT), 32'd0);
    #2;
    HRESET = 1'b1;
    #1;
    check("midrst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("midrst_hresp", 32'(bus.HRESP), 32'd0);
    tick();
    HRESET = 1'b0;
    tick();
    xfer(1'b0, 32'h4, 32'd0, 3'b010, -2, 32'd0, rd, rs, ws);
    check("midrst_status", rd, 32'h0000_0001);
    check("midrst_mode", 32'(cordic_mode), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
